// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : Shared state encoding and timing helpers for the VGA sync path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_ARM  = 2'd1,
    S_DISP = 2'd2
  } vga_state_e;

  typedef struct packed {
    int display;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;

  function automatic int axis_total(input vga_axis_t a);
    return a.display + a.fp + a.sync + a.bp;
  endfunction

  localparam vga_axis_t VGA_H_640 = '{display: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_axis_t VGA_V_480 = '{display: 480, fp: 10, sync: 2, bp: 33};
  localparam int H_TOTAL = axis_total(VGA_H_640);
  localparam int V_TOTAL = axis_total(VGA_V_480);

endpackage

`default_nettype wire

// File: rtl/vga_timing_cnt.sv
// ============================================================================
// Module      : vga_timing_cnt
// Description : Raster h/v counters with active-window, sync and frame strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int H_DISPLAY   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int START_DELAY = 0,
  parameter int H_SIZE      = 11,
  parameter int V_SIZE      = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [H_SIZE-1:0] x_pos,
  output logic [V_SIZE-1:0] v_cnt,
  output logic              video_on,
  output logic              hsync_act,
  output logic              vsync_act,
  output logic              scan_end,
  output logic              last_active
);

  localparam vga_axis_t c_h = '{display: H_DISPLAY, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_axis_t c_v = '{display: V_DISPLAY, fp: V_FP, sync: V_SYNC, bp: V_BP};

  localparam logic [H_SIZE-1:0] c_h_last     = H_SIZE'(axis_total(c_h) - 1);
  localparam logic [H_SIZE-1:0] c_h_delay    = H_SIZE'(START_DELAY);
  localparam logic [H_SIZE-1:0] c_h_disp     = H_SIZE'(H_DISPLAY);
  localparam logic [H_SIZE-1:0] c_h_last_act = H_SIZE'(H_DISPLAY + START_DELAY - 1);
  localparam logic [H_SIZE-1:0] c_h_sync_lo  = H_SIZE'(H_DISPLAY + H_FP);
  localparam logic [H_SIZE-1:0] c_h_sync_hi  = H_SIZE'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [V_SIZE-1:0] c_v_last     = V_SIZE'(axis_total(c_v) - 1);
  localparam logic [V_SIZE-1:0] c_v_disp     = V_SIZE'(V_DISPLAY);
  localparam logic [V_SIZE-1:0] c_v_last_act = V_SIZE'(V_DISPLAY - 1);
  localparam logic [V_SIZE-1:0] c_v_sync_lo  = V_SIZE'(V_DISPLAY + V_FP);
  localparam logic [V_SIZE-1:0] c_v_sync_hi  = V_SIZE'(V_DISPLAY + V_FP + V_SYNC);

  logic [H_SIZE-1:0] h_q, h_d;
  logic [V_SIZE-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == c_h_last) begin
      h_d = '0;
      v_d = (v_q == c_v_last) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Counter width exceeds H_TOTAL+START_DELAY, so columns left of the window
  // wrap to large values and a single unsigned compare bounds both edges.
  assign x_pos       = h_q - c_h_delay;
  assign v_cnt       = v_q;
  assign video_on    = (x_pos < c_h_disp) && (v_q < c_v_disp);
  assign hsync_act   = (h_q >= c_h_sync_lo) && (h_q < c_h_sync_hi);
  assign vsync_act   = (v_q >= c_v_sync_lo) && (v_q < c_v_sync_hi);
  assign scan_end    = (h_q == c_h_last) && (v_q == c_v_last);
  assign last_active = (h_q == c_h_last_act) && (v_q == c_v_last_act);

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : Parametrised VGA timing generator and pixel-stream synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int RSIZE       = 4,
  parameter int GSIZE       = 4,
  parameter int BSIZE       = 4,
  parameter int RGB_SIZE    = 12,
  parameter int H_DISPLAY   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int START_DELAY = 0,
  parameter int FREE_RUN    = 0,
  parameter int H_SIZE      = 11,
  parameter int V_SIZE      = 10
) (
  input  logic                pixel_clk,
  input  logic                pixel_rst,
  input  logic                vga_frame_start,
  input  logic [RGB_SIZE-1:0] vga_src_rgb,
  input  logic                vga_src_vld,
  output logic                vga_src_rdy,
  input  logic                underflow_clr,
  output logic [RSIZE-1:0]    vga_r,
  output logic [GSIZE-1:0]    vga_g,
  output logic [BSIZE-1:0]    vga_b,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_de,
  output logic [H_SIZE-1:0]   vga_x,
  output logic [V_SIZE-1:0]   vga_y,
  output logic                frame_end,
  output logic                underflow,
  output logic                underflow_sticky
);

  localparam logic c_hs_on    = 1'(HSYNC_POL);
  localparam logic c_vs_on    = 1'(VSYNC_POL);
  localparam logic c_free_run = 1'(FREE_RUN);

  logic [H_SIZE-1:0] x_pos;
  logic [V_SIZE-1:0] v_cnt;
  logic              video_on, hsync_act, vsync_act, scan_end, last_active;

  vga_timing_cnt #(
    .H_DISPLAY  (H_DISPLAY),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_DISPLAY  (V_DISPLAY),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP),
    .START_DELAY(START_DELAY),
    .H_SIZE     (H_SIZE),
    .V_SIZE     (V_SIZE)
  ) u_timing (
    .clk        (pixel_clk),
    .rst        (pixel_rst),
    .x_pos      (x_pos),
    .v_cnt      (v_cnt),
    .video_on   (video_on),
    .hsync_act  (hsync_act),
    .vsync_act  (vsync_act),
    .scan_end   (scan_end),
    .last_active(last_active)
  );

  vga_state_e        state_q, state_d;
  logic              arm_q, arm_d;
  logic [RGB_SIZE-1:0] rgb_q, rgb_d;
  logic              de_q, de_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [H_SIZE-1:0] x_q, x_d;
  logic [V_SIZE-1:0] y_q, y_d;
  logic              frame_end_q, frame_end_d;
  logic              underflow_q, underflow_d;
  logic              sticky_q, sticky_d;
  logic              pix_need;

  always_comb begin
    pix_need    = video_on && (state_q == S_DISP);
    state_d     = state_q;
    vga_src_rdy = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        // Drain stale source data until a start request is pending.
        vga_src_rdy = ~vga_frame_start & ~arm_q;
        if (vga_frame_start || arm_q) state_d = scan_end ? S_DISP : S_ARM;
      end
      S_ARM: begin
        if (scan_end) state_d = S_DISP;
      end
      S_DISP: begin
        vga_src_rdy = video_on;
        if (last_active && !c_free_run) state_d = S_SYNC;
      end
      default: state_d = S_SYNC;
    endcase

    arm_d       = (state_d == S_DISP && state_q != S_DISP) ? 1'b0 : (arm_q | vga_frame_start);
    rgb_d       = (pix_need && vga_src_vld) ? vga_src_rgb : '0;
    de_d        = video_on;
    hsync_d     = hsync_act ? c_hs_on : ~c_hs_on;
    vsync_d     = vsync_act ? c_vs_on : ~c_vs_on;
    x_d         = x_pos;
    y_d         = v_cnt;
    frame_end_d = last_active;
    underflow_d = pix_need && !vga_src_vld;
    sticky_d    = underflow_d | (sticky_q & ~underflow_clr);
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q     <= S_SYNC;
      arm_q       <= 1'b0;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      hsync_q     <= ~c_hs_on;
      vsync_q     <= ~c_vs_on;
      x_q         <= '0;
      y_q         <= '0;
      frame_end_q <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_end_q <= frame_end_d;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
    end
  end

  assign vga_r            = rgb_q[RGB_SIZE-1 -: RSIZE];
  assign vga_g            = rgb_q[BSIZE +: GSIZE];
  assign vga_b            = rgb_q[0 +: BSIZE];
  assign vga_hsync        = hsync_q;
  assign vga_vsync        = vsync_q;
  assign vga_de           = de_q;
  assign vga_x            = x_q;
  assign vga_y            = y_q;
  assign frame_end        = frame_end_q;
  assign underflow        = underflow_q;
  assign underflow_sticky = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen (one-shot and free-run).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

  localparam int HD = 8, HT = 14, VD = 4, VT = 7, PER = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fs, vld, clr;
  logic [1:0][11:0] src;
  logic [1:0][11:0] rgb;
  logic [1:0][4:0]  xo;
  logic [1:0][2:0]  yo;
  logic [1:0]       rdy, hs, vs, de, fe, uf, st;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    vga_sync_gen #(
      .RSIZE(4), .GSIZE(4), .BSIZE(4), .RGB_SIZE(12),
      .H_DISPLAY(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(0), .VSYNC_POL(0),
      .START_DELAY(3 * k), .FREE_RUN(k), .H_SIZE(5), .V_SIZE(3)
    ) u_dut (
      .pixel_clk       (clk),
      .pixel_rst       (rst),
      .vga_frame_start (fs),
      .vga_src_rgb     (src[k]),
      .vga_src_vld     (vld),
      .vga_src_rdy     (rdy[k]),
      .underflow_clr   (clr),
      .vga_r           (rgb[k][11:8]),
      .vga_g           (rgb[k][7:4]),
      .vga_b           (rgb[k][3:0]),
      .vga_hsync       (hs[k]),
      .vga_vsync       (vs[k]),
      .vga_de          (de[k]),
      .vga_x           (xo[k]),
      .vga_y           (yo[k]),
      .frame_end       (fe[k]),
      .underflow       (uf[k]),
      .underflow_sticky(st[k])
    );
  end

  typedef struct {
    int t;
    bit hs, vs, de;
    int x, y;
  } vec_t;
  vec_t tbl[12];

  int n_cmp = 0, n_bad = 0;
  int m_sd[2] = '{0, 3};
  bit m_fr[2] = '{1'b0, 1'b1};
  // Reference model: raster position is time since reset modulo the frame.
  int m_t[2], m_mode[2], m_word[2];
  bit m_pend[2];
  logic [11:0] e_rgb[2];
  bit e_de[2], e_hs[2], e_vs[2], e_fe[2], e_uf[2], e_st[2];
  int e_x[2], e_y[2];
  int ref_t;
  bit tbl_on;
  int disp_cnt[2], fe_cnt[2], uf_cnt[2];

  function automatic logic [11:0] wdata(input int k, input int n);
    logic [10:0] lo;
    lo = 11'(n * 151 + k * 77 + 3);
    return {1'b1, lo};
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (time %0t)", nm, k, act, req, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_t[k] = 0; m_mode[k] = 0; m_pend[k] = 1'b0;
    e_rgb[k] = '0; e_de[k] = 0; e_x[k] = 0; e_y[k] = 0;
    e_hs[k] = 1; e_vs[k] = 1; e_fe[k] = 0; e_uf[k] = 0; e_st[k] = 0;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      disp_cnt[k] = 0; fe_cnt[k] = 0; uf_cnt[k] = 0;
    end
  endtask

  task automatic cycle(input bit i_fs, input bit i_vld, input bit i_clr, input bit i_rst);
    int h, v, nm;
    bit von, se, last;
    bit mrdy[2];
    fs = i_fs; vld = i_vld; clr = i_clr; rst = i_rst;
    for (int k = 0; k < 2; k++) src[k] = wdata(k, m_word[k]);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      h = m_t[k] % HT; v = m_t[k] / HT;
      von = (h >= m_sd[k]) && (h < HD + m_sd[k]) && (v < VD);
      mrdy[k] = (m_mode[k] == 0) ? !(i_fs || m_pend[k]) : (m_mode[k] == 1) ? 1'b0 : von;
      chk("rdy", k, rdy[k], mrdy[k]);
      chk("rgb", k, rgb[k], e_rgb[k]);
      chk("de", k, de[k], e_de[k]);
      chk("x", k, xo[k], e_x[k]);
      chk("y", k, yo[k], e_y[k]);
      chk("hsync", k, hs[k], e_hs[k]);
      chk("vsync", k, vs[k], e_vs[k]);
      chk("frame_end", k, fe[k], e_fe[k]);
      chk("underflow", k, uf[k], e_uf[k]);
      chk("sticky", k, st[k], e_st[k]);
      if (de[k] && rgb[k] != '0) disp_cnt[k]++;
      if (fe[k]) fe_cnt[k]++;
      if (uf[k]) uf_cnt[k]++;
    end
    if (tbl_on) begin
      foreach (tbl[i]) begin
        if (tbl[i].t == ref_t) begin
          chk("tbl_hsync", 0, hs[0], tbl[i].hs);
          chk("tbl_vsync", 0, vs[0], tbl[i].vs);
          chk("tbl_de", 0, de[0], tbl[i].de);
          chk("tbl_x", 0, xo[0], tbl[i].x);
          chk("tbl_y", 0, yo[0], tbl[i].y);
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      h = m_t[k] % HT; v = m_t[k] / HT;
      von = (h >= m_sd[k]) && (h < HD + m_sd[k]) && (v < VD);
      if (mrdy[k] && i_vld) m_word[k]++;
      if (i_rst) begin
        model_reset(k);
        if (k == 0) ref_t = -1;
      end else begin
        if (k == 0) ref_t = m_t[0];
        se   = (m_t[k] == PER - 1);
        last = (h == HD + m_sd[k] - 1) && (v == VD - 1);
        e_rgb[k] = (m_mode[k] == 2 && von && i_vld) ? src[k] : 12'h000;
        e_de[k]  = von;
        e_x[k]   = (h - m_sd[k]) & 31;
        e_y[k]   = v;
        e_hs[k]  = !(h >= 10 && h < 12);
        e_vs[k]  = (v != 5);
        e_fe[k]  = last;
        e_uf[k]  = (m_mode[k] == 2) && von && !i_vld;
        e_st[k]  = e_uf[k] || (e_st[k] && !i_clr);
        nm = m_mode[k];
        case (m_mode[k])
          0: if (i_fs || m_pend[k]) nm = se ? 2 : 1;
          1: if (se) nm = 2;
          default: if (last && !m_fr[k]) nm = 0;
        endcase
        m_pend[k] = (nm == 2 && m_mode[k] != 2) ? 1'b0 : (m_pend[k] || i_fs);
        m_mode[k] = nm;
        m_t[k] = (m_t[k] + 1) % PER;
      end
    end
    #1;
  endtask

  task automatic wait_t(input int tgt, input bit need_disp);
    int n;
    n = 0;
    while (!(m_t[0] == tgt && (!need_disp || m_mode[0] == 2)) && n < 400) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    if (n >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_t: bound expired waiting for t=%0d, got t=%0d", tgt, m_t[0]);
    end
  endtask

  initial begin
    tbl[0]  = '{0,  1'b1, 1'b1, 1'b1, 0,  0};
    tbl[1]  = '{7,  1'b1, 1'b1, 1'b1, 7,  0};
    tbl[2]  = '{8,  1'b1, 1'b1, 1'b0, 8,  0};
    tbl[3]  = '{10, 1'b0, 1'b1, 1'b0, 10, 0};
    tbl[4]  = '{11, 1'b0, 1'b1, 1'b0, 11, 0};
    tbl[5]  = '{12, 1'b1, 1'b1, 1'b0, 12, 0};
    tbl[6]  = '{14, 1'b1, 1'b1, 1'b1, 0,  1};
    tbl[7]  = '{55, 1'b1, 1'b1, 1'b0, 13, 3};
    tbl[8]  = '{70, 1'b1, 1'b0, 1'b0, 0,  5};
    tbl[9]  = '{83, 1'b1, 1'b0, 1'b0, 13, 5};
    tbl[10] = '{84, 1'b1, 1'b1, 1'b0, 0,  6};
    tbl[11] = '{97, 1'b1, 1'b1, 1'b0, 13, 6};

    rst = 1'b1; fs = 1'b0; vld = 1'b1; clr = 1'b0; src = '0;
    tbl_on = 1'b0; ref_t = -1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      m_word[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b1);

    // Idle drain over one full frame with fixed timing table on dut0.
    tbl_on = 1'b1;
    repeat (PER + 1) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    tbl_on = 1'b0;

    // One-shot start at h=3, v=2.
    wait_t(31, 1'b0);
    clear_counts();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2 * PER + 20) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("frame_pixels", 0, disp_cnt[0], 32);

    // Underflow at pixel (5,1) of a displayed frame.
    clear_counts();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3 * PER) cycle(1'b0, !(m_mode[0] == 2 && m_t[0] == HT + 5), 1'b0, 1'b0);
    chk("uf_pixels", 0, disp_cnt[0], 31);
    chk("uf_pulses", 0, uf_cnt[0], 1);
    chk("sticky_hold", 0, st[0], 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sticky_clr", 0, st[0], 0);

    // Free-running instance keeps displaying across frames.
    clear_counts();
    repeat (3 * PER) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("free_frame_end", 1, fe_cnt[1], 3);
    chk("free_pixels", 1, disp_cnt[1], 96);
    chk("idle_frame_end", 0, fe_cnt[0], 3);

    // Reset mid-frame at v=2 while displaying.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    wait_t(31, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_de", 0, de[0], 0);
    chk("rst_rdy", 0, rdy[0], 1);
    chk("rst_hsync", 0, hs[0], 1);
    clear_counts();
    repeat (2 * PER) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_no_display", 0, disp_cnt[0], 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 999) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
